// File: rtl/bus_peripheral_pkg.sv
// Shared register map, control-field positions and timer control type for bus_peripheral.
package bus_peripheral_pkg;

    localparam logic [7:0] RAM_BASE    = 8'h00;
    localparam logic [7:0] GPIO_OUT    = 8'h80;
    localparam logic [7:0] GPIO_IN     = 8'h81;
    localparam logic [7:0] TIMER_COUNT = 8'h84;
    localparam logic [7:0] TIMER_CMP   = 8'h85;
    localparam logic [7:0] TIMER_CTRL  = 8'h86;
    localparam logic [7:0] STATUS      = 8'h87;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int STATUS_MATCH_BIT     = 0;

    typedef struct packed {
        logic auto_reload;
        logic enable;
    } timer_ctrl_t;

endpackage

// File: rtl/peripheral_timer.sv
// 8-bit compare timer with optional auto-reload and a sticky match flag.
module peripheral_timer
    import bus_peripheral_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_clear,
    input  logic        cmp_write,
    input  logic        ctrl_write,
    input  logic        status_clear,
    input  logic [7:0]  write_data,
    output logic [7:0]  count,
    output logic [7:0]  cmp,
    output timer_ctrl_t ctrl,
    output logic        match_flag,
    output logic        timer_match
);

    // Compare is a function of registered state only, so the pulse spans exactly the matching cycle.
    assign timer_match = ctrl.enable && (count == cmp);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 8'h00;
            cmp         <= 8'hFF;
            ctrl        <= '0;
            match_flag  <= 1'b0;
        end else begin
            if (count_clear) begin
                count <= 8'h00;
            end else if (timer_match && ctrl.auto_reload) begin
                count <= 8'h00;
            end else if (ctrl.enable) begin
                count <= count + 8'd1;
            end

            if (cmp_write) begin
                cmp <= write_data;
            end

            if (ctrl_write) begin
                ctrl.enable      <= write_data[CTRL_ENABLE_BIT];
                ctrl.auto_reload <= write_data[CTRL_AUTO_RELOAD_BIT];
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (timer_match) begin
                match_flag <= 1'b1;
            end else if (status_clear) begin
                match_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_peripheral.sv
// CPU-bus peripheral: byte RAM, GPIO with input synchronizer, optional timer.
// Define BUS_PERIPHERAL_TIMER_EN to build the timer at 0x84..0x87.
module bus_peripheral
    import bus_peripheral_pkg::*;
#(
    parameter int RAM_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] address,
    input  logic       write_enable,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       timer_match
);

    localparam int AW = $clog2(RAM_BYTES);

    logic [7:0]    ram [RAM_BYTES];
    logic [7:0]    ram_offset;
    logic          ram_hit;
    logic [AW-1:0] ram_index;
    logic [7:0]    gpio_out_q;
    logic [7:0]    sync_meta;
    logic [7:0]    sync_q;

    assign ram_offset = address - RAM_BASE;
    assign ram_hit    = ({1'b0, ram_offset} < 9'(RAM_BYTES));
    assign ram_index  = ram_offset[AW-1:0];
    assign gpio_out   = gpio_out_q;

    // NOTE: RAM has no reset so it maps onto plain memory macros or LUT RAM.
    always_ff @(posedge clk) begin
        if (write_enable && ram_hit) begin
            ram[ram_index] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out_q <= 8'h00;
            sync_meta  <= 8'h00;
            sync_q     <= 8'h00;
        end else begin
            sync_meta <= gpio_in;
            sync_q    <= sync_meta;
            if (write_enable && address == GPIO_OUT) begin
                gpio_out_q <= write_data;
            end
        end
    end

`ifdef BUS_PERIPHERAL_TIMER_EN
    logic [7:0]  timer_count;
    logic [7:0]  timer_cmp;
    timer_ctrl_t timer_ctrl;
    logic        match_flag;

    peripheral_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_clear  (write_enable && address == TIMER_COUNT),
        .cmp_write    (write_enable && address == TIMER_CMP),
        .ctrl_write   (write_enable && address == TIMER_CTRL),
        .status_clear (write_enable && address == STATUS && write_data[STATUS_MATCH_BIT]),
        .write_data   (write_data),
        .count        (timer_count),
        .cmp          (timer_cmp),
        .ctrl         (timer_ctrl),
        .match_flag   (match_flag),
        .timer_match  (timer_match)
    );
`else
    assign timer_match = 1'b0;
`endif

    // NOTE: every path starts from a default so the read mux cannot infer a latch.
    always_comb begin
        read_data = 8'h00;
        if (ram_hit) begin
            read_data = ram[ram_index];
        end else begin
            case (address)
                GPIO_OUT:    read_data = gpio_out_q;
                GPIO_IN:     read_data = sync_q;
`ifdef BUS_PERIPHERAL_TIMER_EN
                TIMER_COUNT: read_data = timer_count;
                TIMER_CMP:   read_data = timer_cmp;
                TIMER_CTRL: begin
                    read_data[CTRL_ENABLE_BIT]      = timer_ctrl.enable;
                    read_data[CTRL_AUTO_RELOAD_BIT] = timer_ctrl.auto_reload;
                end
                STATUS:      read_data[STATUS_MATCH_BIT] = match_flag;
`endif
                default:     read_data = 8'h00;
            endcase
        end
    end

endmodule
